// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and offers words to IF/ID.
// Delivery in the response cycle (L cycles after the request); stall parks the word in HOLD, redirect always wins.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IF_ID,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic        flush_IF
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buf_inst, buf_nxt;
  logic        inst_avail;
  logic [31:0] inst_word;
  logic        offer;
  logic        deliver;
  logic        unused_target_lsb;

  assign unused_target_lsb = ^redirect_target[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      buf_inst <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      buf_inst <= buf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    buf_nxt    = buf_inst;
    inst_avail = 1'b0;
    inst_word  = buf_inst;

    case (state)
      ST_WAIT: begin
        inst_avail = imem_rvalid;
        inst_word  = imem_rdata;
      end
      ST_HOLD: inst_avail = 1'b1;
      default: ;
    endcase

    offer   = inst_avail && !redirect;
    deliver = offer && !stall_IF_ID;

    if (redirect) begin
      pc_nxt    = {redirect_target[31:2], 2'b00};
      state_nxt = ST_REQ;
      // A response still owed by memory must be swallowed before the next request.
      if ((state == ST_WAIT || state == ST_DROP) && !imem_rvalid)
        state_nxt = ST_DROP;
    end else begin
      case (state)
        ST_REQ:  state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid && stall_IF_ID) begin
            buf_nxt   = imem_rdata;
            state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: ;
        ST_DROP: begin
          if (imem_rvalid)
            state_nxt = ST_REQ;
        end
        default: state_nxt = ST_REQ;
      endcase
      if (deliver) begin
        pc_nxt    = pc + 32'd4;
        state_nxt = ST_REQ;
      end
    end
  end

  assign imem_req       = (state == ST_REQ) && !redirect && !reset;
  assign imem_addr      = pc;
  assign IF_Instruction = offer ? inst_word : 32'd0;
  assign IF_PC          = offer ? pc : 32'd0;
  assign flush_IF       = !offer;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: latency-programmable memory model, expected requests and
// offers queued by the stimulus, checked by an independent negedge monitor.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_IF_ID;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic        flush_IF;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_lat = 1;

  logic [31:0] req_q[$];
  logic [63:0] out_q[$];

  if_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_IF_ID    (stall_IF_ID),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .IF_Instruction (IF_Instruction),
    .IF_PC          (IF_PC),
    .flush_IF       (flush_IF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h2008_0005 : a + 32'h1000_0000;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] p, input logic [31:0] w);
    out_q.push_back({p, w});
  endtask

  // Memory model: request seen at negedge, response driven L cycles later.
  initial begin : memory
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = 32'd0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else if (imem_req) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = imem_addr;
      end
    end
  end

  initial begin : monitor
    logic [31:0] ea;
    logic [63:0] eo;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_req) begin
          if (req_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
          end else begin
            ea = req_q.pop_front();
            check("req_addr", {32'd0, imem_addr}, {32'd0, ea});
          end
        end
        if (!flush_IF) begin
          if (out_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_offer: got pc %h inst %h expected bubble", IF_PC, IF_Instruction);
          end else begin
            eo = out_q[0];
            check("offer", {IF_PC, IF_Instruction}, eo);
            if (!stall_IF_ID)
              void'(out_q.pop_front());
          end
        end else begin
          check("bubble", {IF_PC, IF_Instruction}, 64'd0);
        end
        if (redirect)
          check("redirect_flush", {63'd0, flush_IF}, 64'd1);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    stall_IF_ID = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'd0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_req",   {63'd0, imem_req}, 64'd0);
    check("rst_flush", {63'd0, flush_IF}, 64'd1);
    check("rst_inst",  {32'd0, IF_Instruction}, 64'd0);
    check("rst_pc",    {32'd0, IF_PC}, 64'd0);
    check("rst_addr",  {32'd0, imem_addr}, {32'd0, 32'h0040_0000});

    push_req(32'h0040_0000); push_out(32'h0040_0000, 32'h2008_0005);
    push_req(32'h0040_0004); push_out(32'h0040_0004, 32'h1040_0004);
    push_req(32'h0040_0008); push_out(32'h0040_0008, 32'h1040_0008);
    push_req(32'h0040_000C);

    tick(); reset = 1'b0;                         // cycle 1
    @(negedge clk);
    check("c1_req", {63'd0, imem_req}, 64'd1);
    check("c1_addr", {32'd0, imem_addr}, {32'd0, 32'h0040_0000});
    tick();                                       // cycle 2: response
    @(negedge clk);
    check("c2_valid", {63'd0, flush_IF}, 64'd0);
    tick();                                       // cycle 3
    @(negedge clk);
    check("c3_req", {32'd0, imem_req, imem_addr[30:0]}, {32'd0, 1'b1, 31'h0040_0004});
    tick(); stall_IF_ID = 1'b1;                   // cycles 4-6: held
    tick();
    tick();
    @(negedge clk);
    check("stall_noreq", {63'd0, imem_req}, 64'd0);
    tick(); stall_IF_ID = 1'b0;                   // cycle 7: release
    @(negedge clk);
    check("release_deliver", {63'd0, flush_IF}, 64'd0);
    tick();                                       // cycle 8
    @(negedge clk);
    check("c8_req", {63'd0, imem_req}, 64'd1);
    tick(); mem_lat = 3;                          // cycle 9
    tick();                                       // cycle 10: request, L=3
    push_req(32'h0040_0100); push_out(32'h0040_0100, 32'h1040_0100);
    push_req(32'h0040_0104);
    tick(); redirect = 1'b1; redirect_target = 32'h0040_0103;  // cycle 11
    @(negedge clk);
    check("c11_flush", {63'd0, flush_IF}, 64'd1);
    tick(); redirect = 1'b0;                      // cycle 12
    tick();                                       // cycle 13: stale response
    @(negedge clk);
    check("drop_flush", {63'd0, flush_IF}, 64'd1);
    check("drop_noreq", {63'd0, imem_req}, 64'd0);
    tick();                                       // cycle 14
    @(negedge clk);
    check("c14_req", {32'd0, imem_req, imem_addr[30:0]}, {32'd0, 1'b1, 31'h0040_0100});
    repeat (4) tick();                            // cycle 18: request 0x400104
    push_req(32'h0040_0200); push_out(32'h0040_0200, 32'h1040_0200);
    repeat (2) tick();
    tick(); redirect = 1'b1; redirect_target = 32'h0040_0200;  // cycle 21 with rvalid
    @(negedge clk);
    check("c21_rvalid", {63'd0, imem_rvalid}, 64'd1);
    tick(); redirect = 1'b0; mem_lat = 1;         // cycle 22
    @(negedge clk);
    check("c22_req", {32'd0, imem_req, imem_addr[30:0]}, {32'd0, 1'b1, 31'h0040_0200});
    tick();                                       // cycle 23: delivered
    tick(); redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;  // cycle 24 in REQ
    push_req(32'hFFFF_FFFC); push_out(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    push_req(32'h0000_0000); push_out(32'h0000_0000, 32'h1000_0000);
    push_req(32'h0000_0004);
    @(negedge clk);
    check("c24_suppress", {63'd0, imem_req}, 64'd0);
    tick(); redirect = 1'b0;                      // cycle 25
    tick();                                       // cycle 26
    tick();                                       // cycle 27
    @(negedge clk);
    check("wrap_addr", {32'd0, imem_req, imem_addr[30:0]}, {32'd0, 1'b1, 31'd0});
    tick(); mem_lat = 3;                          // cycle 28
    tick();                                       // cycle 29: request 0x4
    tick();                                       // cycle 30: WAIT
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_flush", {63'd0, flush_IF}, 64'd1);
    check("mid_rst_out",   {IF_PC, IF_Instruction}, 64'd0);
    check("mid_rst_req",   {63'd0, imem_req}, 64'd0);
    check("mid_rst_addr",  {32'd0, imem_addr}, {32'd0, 32'h0040_0000});
    push_req(32'h0040_0000); push_out(32'h0040_0000, 32'h2008_0005);
    push_req(32'h0040_0004);
    tick();
    tick(); reset = 1'b0;                         // R1
    @(negedge clk);
    check("r1_req", {32'd0, imem_req, imem_addr[30:0]}, {32'd0, 1'b1, 31'h0040_0000});
    repeat (4) tick();                            // R5
    @(negedge clk);
    check("r5_req", {32'd0, imem_req, imem_addr[30:0]}, {32'd0, 1'b1, 31'h0040_0004});
    tick(); reset = 1'b1;
    repeat (2) tick();
    check("req_q_empty", {32'd0, req_q.size()}, 64'd0);
    check("out_q_empty", {32'd0, out_q.size()}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
